prt_scaler_tdet: RTL and testbench

- Video timing detector, the measuring counterpart of the scaler timing generator.
- Observes an incoming VS/HS/DE stream and measures its raster geometry.
- Once two consecutive frames measure identically, it emits the eight-word video parameter set (VPS) in the same index/data/valid format the timing generator consumes, so the sink timing can be programmed from the source.
- Sits on the scaler input side, ahead of the scaler core and timing generator.

---
 rtl/prt_scaler_tdet.sv | 201 ++++++++++++++++++++
 tb/tb_prt_scaler_tdet.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prt_scaler_tdet.sv
// Video timing detector: measures VS/HS/DE raster geometry and, once two
// consecutive frames measure identically, emits the eight-word video
// parameter set (index/data/valid) used to program the sink timing generator.
//
// state | meaning
// IDLE  | run low, lock cleared, nothing compared
// SYNC  | waiting for the first VS rise; partial frame discarded
// MEAS  | measuring; each VS rise compares against the previous frame
// EMIT  | eight-cycle parameter burst from a latched snapshot
module prt_scaler_tdet #(
  parameter int P_PPC = 4
) (
  input  logic        CLK_IN,
  input  logic        RST_IN,
  input  logic        CKE_IN,
  input  logic        CTL_RUN_IN,
  input  logic        VID_VS_IN,
  input  logic        VID_HS_IN,
  input  logic        VID_DE_IN,
  output logic [3:0]  VPS_IDX_OUT,
  output logic [15:0] VPS_DAT_OUT,
  output logic        VPS_VLD_OUT,
  output logic        STA_LOCK_OUT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;
  localparam logic [1:0] S_EMIT = 2'd3;

  localparam logic [15:0] PPC = 16'(P_PPC);

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic        samp;
  logic        vs_q, hs_q, de_q;
  logic        vs_p, hs_p, de_p;
  logic        vs_rise, vs_fall, hs_rise, hs_fall, de_rise, de_fall;

  logic [15:0] hcnt, hact;
  logic [15:0] htotal, hsw, hstart, hwidth;
  logic [15:0] vcnt, vde, vstart, vsw;
  logic        de_seen;

  logic [1:0]        state;
  logic              lock;
  logic [7:0][15:0]  cur, copy, snap;
  logic              copy_vld;
  logic [2:0]        emit_cnt;
  logic              pend;
  logic              match, pend_nxt, tmo;

  // Register the video inputs on CKE; samp marks the cycle that evaluates a new sample pair.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      samp <= 1'b0;
      vs_q <= 1'b0; hs_q <= 1'b0; de_q <= 1'b0;
      vs_p <= 1'b0; hs_p <= 1'b0; de_p <= 1'b0;
    end else begin
      samp <= CKE_IN;
      if (CKE_IN) begin
        vs_q <= VID_VS_IN; hs_q <= VID_HS_IN; de_q <= VID_DE_IN;
        vs_p <= vs_q;      hs_p <= hs_q;      de_p <= de_q;
      end
    end
  end

  assign vs_rise = samp &  vs_q & ~vs_p;
  assign vs_fall = samp & ~vs_q &  vs_p;
  assign hs_rise = samp &  hs_q & ~hs_p;
  assign hs_fall = samp & ~hs_q &  hs_p;
  assign de_rise = samp &  de_q & ~de_p;
  assign de_fall = samp & ~de_q &  de_p;

  // Horizontal measurement: position counter and per-line captures.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      hcnt <= '0; hact <= '0;
      htotal <= '0; hsw <= '0; hstart <= '0; hwidth <= '0;
    end else if (samp) begin
      if (hs_rise) begin
        htotal <= hcnt;
        hcnt   <= PPC;
      end else begin
        hcnt <= sat_add(hcnt, PPC);
      end
      if (hs_fall) hsw <= hcnt;
      if (de_rise) begin
        hstart <= hcnt;
        hact   <= PPC;
      end else if (de_q) begin
        hact <= sat_add(hact, PPC);
      end
      if (de_fall) hwidth <= hact;
    end
  end

  // Vertical measurement: line count since VS rise and per-frame captures.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      vcnt <= '0; vde <= '0; vstart <= '0; vsw <= '0; de_seen <= 1'b0;
    end else if (samp) begin
      if (vs_rise) begin
        vcnt    <= hs_rise ? 16'd1 : 16'd0;
        vde     <= de_rise ? 16'd1 : 16'd0;
        de_seen <= de_rise;
        vstart  <= '0;
        vsw     <= '0;
      end else begin
        if (hs_rise) vcnt <= sat_add(vcnt, 16'd1);
        if (de_rise) begin
          vde <= sat_add(vde, 16'd1);
          if (!de_seen) begin
            vstart  <= (vcnt == 16'd0) ? 16'd0 : vcnt - 16'd1;
            de_seen <= 1'b1;
          end
        end
        // A coincident HS rise is not yet in vcnt, so it does not count toward vsw.
        if (vs_fall) vsw <= vcnt;
      end
    end
  end

  // Frame result as seen at the VS rise, before that sample updates anything.
  assign cur = {vsw, vstart, vde, vcnt, hsw, hstart, hwidth, htotal};

  // Frame compare result and pending-burst request for a VS rise seen mid-burst.
  always_comb begin
    match    = copy_vld && (cur == copy);
    pend_nxt = vs_rise ? match : pend;
    tmo      = (hcnt == 16'hFFFF) || (vcnt == 16'hFFFF);
  end

  // Sequencing: sync, compare consecutive frames, emit bursts.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state <= S_IDLE; lock <= 1'b0; copy <= '0; copy_vld <= 1'b0;
      snap <= '0; emit_cnt <= '0; pend <= 1'b0;
    end else if (!CTL_RUN_IN) begin
      state <= S_IDLE; lock <= 1'b0; copy_vld <= 1'b0;
      emit_cnt <= '0; pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          lock     <= 1'b0;
          copy_vld <= 1'b0;
          state    <= S_SYNC;
        end
        S_SYNC: if (vs_rise) state <= S_MEAS;
        S_MEAS: begin
          if (tmo) begin
            state    <= S_SYNC;
            lock     <= 1'b0;
            copy_vld <= 1'b0;
          end else if (vs_rise) begin
            copy     <= cur;
            copy_vld <= 1'b1;
            lock     <= match;
            if (match) begin
              snap     <= cur;
              emit_cnt <= '0;
              pend     <= 1'b0;
              state    <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (vs_rise) begin
            copy     <= cur;
            copy_vld <= 1'b1;
            lock     <= match;
          end
          // A burst always runs to completion; a queued request restarts it.
          if (emit_cnt == 3'd7) begin
            pend <= 1'b0;
            if (pend_nxt) begin
              snap     <= vs_rise ? cur : copy;
              emit_cnt <= '0;
            end else begin
              state <= S_MEAS;
            end
          end else begin
            emit_cnt <= emit_cnt + 3'd1;
            pend     <= pend_nxt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign VPS_VLD_OUT  = (state == S_EMIT);
  assign VPS_IDX_OUT  = VPS_VLD_OUT ? {1'b0, emit_cnt} : 4'd0;
  assign VPS_DAT_OUT  = VPS_VLD_OUT ? snap[emit_cnt] : 16'd0;
  assign STA_LOCK_OUT = lock;

endmodule

// File: tb/tb_prt_scaler_tdet.sv
// Bench for prt_scaler_tdet: frame-level model of the raster geometry and of
// the lock/burst decision, driven with table rasters and random rasters.
module tb_prt_scaler_tdet;

  localparam int P = 4;

  typedef struct {
    int l; int hsw; int s; int d; int n; int vsw; int v0; int v;
  } raster_t;
  typedef logic [7:0][15:0] geom_t;
  typedef struct {
    raster_t r; bit crand; geom_t e;
  } vec_t;

  logic        CLK_IN = 1'b0;
  logic        RST_IN;
  logic        CKE_IN;
  logic        CTL_RUN_IN;
  logic        VID_VS_IN, VID_HS_IN, VID_DE_IN;
  logic [3:0]  VPS_IDX_OUT;
  logic [15:0] VPS_DAT_OUT;
  logic        VPS_VLD_OUT;
  logic        STA_LOCK_OUT;

  int checks = 0;
  int failures = 0;

  logic [19:0] mq[$];
  geom_t       hist[$];
  geom_t       last_b;
  raster_t     prev_r;
  int          nfr;
  bit          found;

  prt_scaler_tdet #(.P_PPC(P)) dut (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN), .CKE_IN(CKE_IN), .CTL_RUN_IN(CTL_RUN_IN),
    .VID_VS_IN(VID_VS_IN), .VID_HS_IN(VID_HS_IN), .VID_DE_IN(VID_DE_IN),
    .VPS_IDX_OUT(VPS_IDX_OUT), .VPS_DAT_OUT(VPS_DAT_OUT),
    .VPS_VLD_OUT(VPS_VLD_OUT), .STA_LOCK_OUT(STA_LOCK_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  // collect every valid parameter word
  always @(negedge CLK_IN)
    if (VPS_VLD_OUT === 1'b1) mq.push_back({VPS_IDX_OUT, VPS_DAT_OUT});

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // geometry a regular raster should measure to
  function automatic geom_t geom(input raster_t r);
    geom_t g;
    g[0] = 16'(r.l * P);
    g[1] = 16'(r.d * P);
    g[2] = 16'(r.s * P);
    g[3] = 16'(r.hsw * P);
    g[4] = 16'(r.n);
    g[5] = 16'(r.v);
    g[6] = 16'(r.v0);
    g[7] = 16'(r.vsw);
    return g;
  endfunction

  function automatic raster_t rnd_raster();
    raster_t r;
    r.l   = int'($urandom_range(12, 24));
    r.hsw = int'($urandom_range(1, 3));
    r.s   = int'($urandom_range(1, 4));
    r.d   = int'($urandom_range(1, r.l - r.s - 1));
    r.n   = int'($urandom_range(6, 12));
    r.vsw = int'($urandom_range(1, 2));
    r.v0  = int'($urandom_range(0, 3));
    r.v   = int'($urandom_range(1, r.n - r.v0));
    return r;
  endfunction

  task automatic drive_frame(input raster_t r, input bit crand);
    bit c;
    for (int k = 0; k < r.n; k++) begin
      for (int j = 0; j < r.l; j++) begin
        VID_VS_IN = (k < r.vsw);
        VID_HS_IN = (j < r.hsw);
        VID_DE_IN = (k >= r.v0) && (k < r.v0 + r.v) && (j >= r.s) && (j < r.s + r.d);
        do begin
          c = crand ? 1'($urandom_range(0, 1)) : 1'b1;
          CKE_IN = c;
          @(negedge CLK_IN);
        end while (!c);
      end
    end
    CKE_IN = 1'b1;
  endtask

  task automatic restart();
    CTL_RUN_IN = 1'b0;
    CKE_IN = 1'b1;
    repeat (3) @(negedge CLK_IN);
    CTL_RUN_IN = 1'b1;
    nfr = 0;
    hist.delete();
  endtask

  // one frame: the VS rise at its start closes the previous frame
  task automatic step(input raster_t r, input bit crand);
    geom_t g;
    bit el;
    if (nfr > 0) hist.push_back(geom(prev_r));
    el = (hist.size() >= 2) && (hist[hist.size()-1] == hist[hist.size()-2]);
    mq.delete();
    last_b = '0;
    drive_frame(r, crand);
    chk("lock", {31'd0, STA_LOCK_OUT}, {31'd0, el});
    if (el) begin
      g = hist[hist.size()-1];
      chk("burst_len", mq.size(), 8);
      for (int i = 0; i < 8; i++) begin
        if (i < mq.size()) begin
          chk($sformatf("idx%0d", i), {28'd0, mq[i][19:16]}, i);
          chk($sformatf("dat%0d", i), {16'd0, mq[i][15:0]}, {16'd0, g[i]});
        end
      end
    end else begin
      chk("no_burst", mq.size(), 0);
    end
    foreach (mq[i]) last_b[mq[i][18:16]] = mq[i][15:0];
    prev_r = r;
    nfr++;
  endtask

  vec_t    vec[3];
  raster_t ra, rb, rc;

  initial begin
    vec[0].r = '{16, 2, 3, 10, 8, 1, 2, 4};
    vec[0].crand = 1'b0;
    vec[0].e = {16'd1, 16'd2, 16'd4, 16'd8, 16'd8, 16'd12, 16'd40, 16'd64};
    vec[1].r = '{16, 2, 3, 10, 8, 1, 2, 4};
    vec[1].crand = 1'b1;
    vec[1].e = {16'd1, 16'd2, 16'd4, 16'd8, 16'd8, 16'd12, 16'd40, 16'd64};
    vec[2].r = '{20, 3, 4, 12, 10, 2, 3, 5};
    vec[2].crand = 1'b1;
    vec[2].e = {16'd2, 16'd3, 16'd5, 16'd10, 16'd12, 16'd16, 16'd48, 16'd80};

    RST_IN = 1'b1; CTL_RUN_IN = 1'b0; CKE_IN = 1'b0;
    VID_VS_IN = 1'b0; VID_HS_IN = 1'b0; VID_DE_IN = 1'b0;
    nfr = 0;
    repeat (3) @(negedge CLK_IN);
    chk("rst_idx",  {28'd0, VPS_IDX_OUT}, 0);
    chk("rst_dat",  {16'd0, VPS_DAT_OUT}, 0);
    chk("rst_vld",  {31'd0, VPS_VLD_OUT}, 0);
    chk("rst_lock", {31'd0, STA_LOCK_OUT}, 0);
    RST_IN = 1'b0;
    @(negedge CLK_IN);

    // table rasters: lock after two matching frames, burst equals table
    for (int t = 0; t < 3; t++) begin
      restart();
      repeat (3) step(vec[t].r, vec[t].crand);
      for (int i = 0; i < 8; i++)
        chk($sformatf("tbl%0d_%0d", t, i), {16'd0, last_b[i]}, {16'd0, vec[t].e[i]});
    end

    // line length change: lock drops, then relocks with the new htotal
    ra = vec[0].r;
    rb = ra; rb.l = 18;
    restart();
    repeat (3) step(ra, 1'b0);
    repeat (3) step(rb, 1'b0);
    chk("new_htotal", {16'd0, last_b[0]}, 72);

    // hcnt saturation with no sync: lock drops, no burst, resync afterwards
    restart();
    repeat (3) step(ra, 1'b0);
    mq.delete();
    VID_VS_IN = 1'b0; VID_HS_IN = 1'b0; VID_DE_IN = 1'b0; CKE_IN = 1'b1;
    repeat (16400) @(negedge CLK_IN);
    chk("tmo_lock", {31'd0, STA_LOCK_OUT}, 0);
    chk("tmo_noburst", mq.size(), 0);
    nfr = 0; hist.delete();
    repeat (3) step(vec[2].r, 1'b0);

    // run dropped at burst index 3
    restart();
    repeat (3) step(ra, 1'b0);
    mq.delete();
    found = 1'b0;
    fork
      drive_frame(ra, 1'b0);
      begin
        for (int t = 0; t < 200 && !found; t++) begin
          @(negedge CLK_IN);
          if (VPS_VLD_OUT === 1'b1 && VPS_IDX_OUT == 4'd3) begin
            found = 1'b1;
            CTL_RUN_IN = 1'b0;
            @(negedge CLK_IN);
            chk("abort_vld",  {31'd0, VPS_VLD_OUT}, 0);
            chk("abort_lock", {31'd0, STA_LOCK_OUT}, 0);
          end
        end
      end
    join
    chk("abort_found", {31'd0, found}, 1);
    chk("abort_len", mq.size(), 4);
    CTL_RUN_IN = 1'b1;
    nfr = 0; hist.delete();
    repeat (3) step(ra, 1'b1);

    // asynchronous reset mid-frame, then relock
    fork
      drive_frame(ra, 1'b0);
      begin
        repeat (40) @(negedge CLK_IN);
        chk("pre_rst_lock", {31'd0, STA_LOCK_OUT}, 1);
        #2 RST_IN = 1'b1;
        #1;
        chk("arst_lock", {31'd0, STA_LOCK_OUT}, 0);
        chk("arst_vld",  {31'd0, VPS_VLD_OUT}, 0);
        chk("arst_idx",  {28'd0, VPS_IDX_OUT}, 0);
        chk("arst_dat",  {16'd0, VPS_DAT_OUT}, 0);
        repeat (2) @(negedge CLK_IN);
        RST_IN = 1'b0;
      end
    join
    nfr = 0; hist.delete();
    repeat (3) step(ra, 1'b0);

    // random rasters, mostly repeating, random clock enable
    ra = rnd_raster();
    rb = rnd_raster();
    restart();
    for (int f = 0; f < 14; f++) begin
      rc = ($urandom_range(0, 3) != 0) ? ra : rb;
      step(rc, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
